// File: rtl/mod_down_pkg.sv
// Shared types and sizing for the ModDown stage (P -> Q basis drop after fast base conversion).
package mod_down_pkg;
   localparam int unsigned RNS_PRIME_BITS = 30;
   localparam int unsigned WIDE_BITS      = 2 * RNS_PRIME_BITS;
   localparam int unsigned N_SLOTS        = 4;

   typedef logic [RNS_PRIME_BITS-1:0] rns_residue_t;
   typedef logic [WIDE_BITS-1:0]      wide_rns_residue_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } md_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mod_down_lane.sv
// One combinational lane: ((xr - cr) mod q) * pinv mod q.
module mod_down_lane
   import mod_down_pkg::*;
(
   input  rns_residue_t xr,
   input  rns_residue_t cr,
   input  rns_residue_t q,
   input  rns_residue_t pinv,
   output rns_residue_t residue
);
   logic [RNS_PRIME_BITS:0] w_diff;
   wide_rns_residue_t       w_prod;

   always_comb begin
      if (xr >= cr) w_diff = {1'b0, xr} - {1'b0, cr};
      else          w_diff = {1'b0, xr} + {1'b0, q} - {1'b0, cr};
      w_prod = wide_rns_residue_t'(w_diff) * wide_rns_residue_t'(pinv);
   end

   assign residue = rns_residue_t'(w_prod % wide_rns_residue_t'(q));
endmodule

// File: rtl/mod_down.sv
// ModDown controller: latches x/c, walks the Q primes one per cycle, all slots in parallel.
module mod_down
   import mod_down_pkg::*;
#(
   parameter int unsigned  Q_LEN = 2,
   parameter rns_residue_t Q_BASIS    [Q_LEN] = '{17, 13},
   parameter rns_residue_t P_INV_MODQ [Q_LEN] = '{5, 2}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  rns_residue_t x_poly   [N_SLOTS][Q_LEN],
   input  rns_residue_t c_poly   [N_SLOTS][Q_LEN],
   output logic         out_valid,
   output rns_residue_t out_poly [N_SLOTS][Q_LEN],
   output logic         busy
);
   localparam int unsigned IDX_W = idx_width(Q_LEN);

   if (Q_LEN < 1) begin : g_bad_len
      $fatal(1, "mod_down: Q_LEN must be at least 1");
   end
   for (genvar j = 0; j < Q_LEN; j++) begin : g_chk
      if (Q_BASIS[j] == 0 || P_INV_MODQ[j] == 0) begin : g_bad_const
         $fatal(1, "mod_down: zero entry in Q_BASIS or P_INV_MODQ");
      end
   end

   md_state_t    r_state;
   logic [IDX_W-1:0] r_idx;
   rns_residue_t r_xr  [N_SLOTS][Q_LEN];
   rns_residue_t r_cr  [N_SLOTS][Q_LEN];
   rns_residue_t r_out [N_SLOTS][Q_LEN];
   rns_residue_t w_res [N_SLOTS];

   for (genvar s = 0; s < N_SLOTS; s++) begin : g_lane
      mod_down_lane u_lane (
         .xr      (r_xr[s][r_idx]),
         .cr      (r_cr[s][r_idx]),
         .q       (Q_BASIS[r_idx]),
         .pinv    (P_INV_MODQ[r_idx]),
         .residue (w_res[s])
      );
   end

   // in_valid restarts from any state; reset still takes priority over it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         for (int unsigned s = 0; s < N_SLOTS; s++) begin
            for (int unsigned j = 0; j < Q_LEN; j++) begin
               r_out[s][j] <= '0;
               r_xr[s][j]  <= '0;
               r_cr[s][j]  <= '0;
            end
         end
      end else if (in_valid) begin
         r_state <= ST_RUN;
         r_idx   <= '0;
         for (int unsigned s = 0; s < N_SLOTS; s++) begin
            for (int unsigned j = 0; j < Q_LEN; j++) begin
               r_out[s][j] <= '0;
               r_xr[s][j]  <= x_poly[s][j];
               r_cr[s][j]  <= c_poly[s][j];
            end
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               for (int unsigned s = 0; s < N_SLOTS; s++) begin
                  r_out[s][r_idx] <= w_res[s];
               end
               if (r_idx == IDX_W'(Q_LEN - 1)) r_state <= ST_DONE;
               else                            r_idx   <= r_idx + 1'b1;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state == ST_RUN);
   assign out_poly  = r_out;
endmodule

// File: tb/tb_mod_down.sv
// Directed table-driven checks on the {17,13} instance plus randomised jobs on a 30-bit instance.
module tb_mod_down;
   import mod_down_pkg::*;

   localparam int unsigned QL = 2;
   localparam rns_residue_t BQ0 = 30'd1073741789;
   localparam rns_residue_t BQ1 = 30'd1073741783;
   localparam rns_residue_t BP0 = 30'd123456789;
   localparam rns_residue_t BP1 = 30'd987654321;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sm_in_valid = 1'b0;
   logic bg_in_valid = 1'b0;
   rns_residue_t sm_x [N_SLOTS][QL];
   rns_residue_t sm_c [N_SLOTS][QL];
   rns_residue_t sm_out [N_SLOTS][QL];
   logic sm_out_valid, sm_busy;
   rns_residue_t bg_x [N_SLOTS][QL];
   rns_residue_t bg_c [N_SLOTS][QL];
   rns_residue_t bg_out [N_SLOTS][QL];
   logic bg_out_valid, bg_busy;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   mod_down #(.Q_LEN(QL), .Q_BASIS('{17, 13}), .P_INV_MODQ('{5, 2})) u_small (
      .clk(clk), .reset(reset), .in_valid(sm_in_valid), .x_poly(sm_x), .c_poly(sm_c),
      .out_valid(sm_out_valid), .out_poly(sm_out), .busy(sm_busy)
   );

   mod_down #(.Q_LEN(QL), .Q_BASIS('{BQ0, BQ1}), .P_INV_MODQ('{BP0, BP1})) u_big (
      .clk(clk), .reset(reset), .in_valid(bg_in_valid), .x_poly(bg_x), .c_poly(bg_c),
      .out_valid(bg_out_valid), .out_poly(bg_out), .busy(bg_busy)
   );

   typedef struct {
      rns_residue_t x [N_SLOTS][QL];
      rns_residue_t c [N_SLOTS][QL];
      rns_residue_t e [N_SLOTS][QL];
   } vec_t;
   vec_t vecs [3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_ctl(input string name, input logic ov, input logic bz);
      check({name, ".out_valid"}, longint'(sm_out_valid), longint'(ov));
      check({name, ".busy"}, longint'(sm_busy), longint'(bz));
   endtask

   task automatic load(input int v);
      for (int s = 0; s < N_SLOTS; s++)
         for (int j = 0; j < QL; j++) begin
            sm_x[s][j] = vecs[v].x[s][j];
            sm_c[s][j] = vecs[v].c[s][j];
         end
   endtask

   task automatic scramble();
      for (int s = 0; s < N_SLOTS; s++)
         for (int j = 0; j < QL; j++) begin
            sm_x[s][j] = 30'd7;
            sm_c[s][j] = 30'd3;
         end
   endtask

   // cols < 0 compares all primes; otherwise entries j >= cols must still be 0.
   task automatic check_out(input string name, input int v, input int cols);
      for (int s = 0; s < N_SLOTS; s++)
         for (int j = 0; j < QL; j++) begin
            if (cols < 0 || j < cols)
               check($sformatf("%s.out[%0d][%0d]", name, s, j), longint'(sm_out[s][j]),
                     longint'(vecs[v].e[s][j]));
            else
               check($sformatf("%s.unwritten[%0d][%0d]", name, s, j), longint'(sm_out[s][j]), 0);
         end
   endtask

   task automatic check_zero(input string name);
      for (int s = 0; s < N_SLOTS; s++)
         for (int j = 0; j < QL; j++)
            check($sformatf("%s.zero[%0d][%0d]", name, s, j), longint'(sm_out[s][j]), 0);
   endtask

   initial begin
      vecs[0].x = '{'{10, 4}, '{5, 0}, '{0, 12}, '{1, 1}};
      vecs[0].c = '{'{3, 9}, '{5, 12}, '{16, 0}, '{0, 0}};
      vecs[0].e = '{'{1, 3}, '{0, 2}, '{5, 11}, '{5, 2}};
      vecs[1].x = '{'{16, 12}, '{0, 0}, '{2, 3}, '{8, 6}};
      vecs[1].c = '{'{0, 0}, '{0, 0}, '{9, 7}, '{8, 5}};
      vecs[1].e = '{'{12, 11}, '{0, 0}, '{16, 5}, '{0, 2}};
      vecs[2].x = '{'{0, 0}, '{9, 7}, '{13, 10}, '{3, 11}};
      vecs[2].c = '{'{16, 12}, '{2, 3}, '{6, 1}, '{4, 12}};
      vecs[2].e = '{'{5, 2}, '{1, 8}, '{1, 5}, '{12, 11}};
      scramble();
      for (int s = 0; s < N_SLOTS; s++)
         for (int j = 0; j < QL; j++) begin
            bg_x[s][j] = '0;
            bg_c[s][j] = '0;
         end

      // Reset state; reset beats a simultaneous in_valid.
      tick();
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      check_ctl("reset", 1'b0, 1'b0);
      check_zero("reset");
      reset = 1'b0;
      tick();

      // Table-driven jobs with full latency profile.
      for (int v = 0; v < 3; v++) begin
         load(v);
         sm_in_valid = 1'b1;
         tick();
         sm_in_valid = 1'b0;
         scramble();
         check_ctl($sformatf("v%0d.E0", v), 1'b0, 1'b1);
         check_zero($sformatf("v%0d.E0", v));
         tick();
         check_ctl($sformatf("v%0d.E1", v), 1'b0, 1'b1);
         check_out($sformatf("v%0d.E1", v), v, 1);
         tick();
         check_ctl($sformatf("v%0d.E2", v), 1'b1, 1'b0);
         check_out($sformatf("v%0d.E2", v), v, -1);
         tick();
         check_ctl($sformatf("v%0d.E3", v), 1'b0, 1'b0);
         check_out($sformatf("v%0d.hold", v), v, -1);
      end

      // Restart while busy at idx=1 with x={1,1}, c={0,0} in every slot.
      load(1);
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      tick();
      for (int s = 0; s < N_SLOTS; s++) begin
         sm_x[s] = '{1, 1};
         sm_c[s] = '{0, 0};
      end
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      scramble();
      check_ctl("restart.E2", 1'b0, 1'b1);
      check_zero("restart.E2");
      tick();
      check_ctl("restart.E3", 1'b0, 1'b1);
      tick();
      check_ctl("restart.E4", 1'b1, 1'b0);
      for (int s = 0; s < N_SLOTS; s++) begin
         check($sformatf("restart.out[%0d][0]", s), longint'(sm_out[s][0]), 5);
         check($sformatf("restart.out[%0d][1]", s), longint'(sm_out[s][1]), 2);
      end
      tick();

      // Reset in the middle of RUN, then a normal job.
      load(2);
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_ctl("midreset", 1'b0, 1'b0);
      check_zero("midreset");
      tick();
      check_ctl("midreset.after", 1'b0, 1'b0);
      load(1);
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      tick();
      tick();
      check_ctl("postreset.E2", 1'b1, 1'b0);
      check_out("postreset", 1, -1);
      tick();

      // Back-to-back: second start during the DONE cycle.
      load(0);
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      tick();
      tick();
      check_ctl("b2b.first", 1'b1, 1'b0);
      check_out("b2b.first", 0, -1);
      load(2);
      sm_in_valid = 1'b1;
      tick();
      sm_in_valid = 1'b0;
      check_ctl("b2b.restart", 1'b0, 1'b1);
      check_zero("b2b.restart");
      tick();
      tick();
      check_ctl("b2b.second", 1'b1, 1'b0);
      check_out("b2b.second", 2, -1);
      tick();

      // Random jobs on 30-bit moduli against ((x + q - c) mod q) * pinv mod q.
      for (int n = 0; n < 1000; n++) begin
         longint unsigned qq [QL];
         longint unsigned pp [QL];
         longint unsigned exp_r [N_SLOTS][QL];
         qq = '{longint'(BQ0), longint'(BQ1)};
         pp = '{longint'(BP0), longint'(BP1)};
         for (int s = 0; s < N_SLOTS; s++)
            for (int j = 0; j < QL; j++) begin
               longint unsigned xv, cv;
               case ($urandom_range(7))
                  0: begin xv = 0; cv = qq[j] - 1; end
                  1: begin xv = qq[j] - 1; cv = xv; end
                  2: begin xv = qq[j] - 1; cv = 0; end
                  default: begin
                     xv = longint'($urandom_range(32'(qq[j] - 1)));
                     cv = longint'($urandom_range(32'(qq[j] - 1)));
                  end
               endcase
               bg_x[s][j] = rns_residue_t'(xv);
               bg_c[s][j] = rns_residue_t'(cv);
               exp_r[s][j] = (((xv + qq[j] - cv) % qq[j]) * pp[j]) % qq[j];
            end
         bg_in_valid = 1'b1;
         tick();
         bg_in_valid = 1'b0;
         tick();
         tick();
         check($sformatf("rand%0d.out_valid", n), longint'(bg_out_valid), 1);
         for (int s = 0; s < N_SLOTS; s++)
            for (int j = 0; j < QL; j++)
               check($sformatf("rand%0d.out[%0d][%0d]", n, s, j), longint'(bg_out[s][j]),
                     exp_r[s][j]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
